// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: round-robin arbiter for NREQ requesters producing a binary
// grant index plus a grant-valid strobe, meant to drive the select/enable pins
// of a downstream 3-to-8 one-hot decoder.
//
// A grant is held until the owner raises done or drops its request.
// Every grant is followed by at least one IDLE cycle with gnt_vld low.
// After a grant, the pointer moves one past the owner, so the owner has the
// lowest priority in the next arbitration.
//
// Optional feature, macro RR_GRANT_TIMEOUT_EN:
//   When defined, an 8-bit hold counter forces a release after MAX_HOLD grant
//   cycles and emits a one-cycle timeout pulse.
//   When undefined, no counter exists and timeout is tied low.
module rr_grant_encoder #(
  parameter int IDX_W    = 3,
  parameter int NREQ     = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  // The index arithmetic wraps at 2**IDX_W. That only matches NREQ when the
  // two agree. The hold counter is 8 bits, which bounds MAX_HOLD.
  if (NREQ != (1 << IDX_W) || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_cfg
    $error("rr_grant_encoder: illegal IDX_W/NREQ/MAX_HOLD combination");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_vld, w_vld_nxt;
  logic [IDX_W-1:0] w_winner;
  logic             w_any;
  logic             w_release;
  logic             w_expire;

  // Winner: the first set request bit, scanning upward from r_ptr with wrap.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    w_winner = r_ptr;
    w_any    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_any && req[r_ptr + IDX_W'(i)]) begin
        w_winner = r_ptr + IDX_W'(i);
        w_any    = 1'b1;
      end
    end
  end

  // The owner finished or withdrew its request; both together are one release.
  assign w_release = done || !req[r_idx];

`ifdef RR_GRANT_TIMEOUT_EN
  logic [7:0] r_hold, w_hold_nxt;
  logic       r_timeout, w_timeout_nxt;

  assign w_expire = (r_hold == 8'(MAX_HOLD - 1));

  // Hold counter: held at zero in IDLE so it starts at 0 on GRANT entry.
  // A normal release in the same cycle as expiry suppresses the pulse.
  always_comb begin
    w_hold_nxt    = 8'd0;
    w_timeout_nxt = 1'b0;
    if (r_state == S_GRANT) begin
      w_hold_nxt    = r_hold + 8'd1;
      w_timeout_nxt = w_expire && !w_release;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Next state: arbitrate in IDLE; in GRANT, hold until a release or expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_vld_nxt   = r_vld;
    case (r_state)
      S_IDLE: begin
        w_vld_nxt = 1'b0;
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_idx_nxt   = w_winner;
          w_vld_nxt   = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_release || w_expire) begin
          w_state_nxt = S_IDLE;
          w_vld_nxt   = 1'b0;
          w_ptr_nxt   = r_idx + IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_vld_nxt   = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs. Reset acts without a clock edge,
  // so a mid-grant reset drops gnt_vld at once.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments, so every register
    // samples values from before the edge regardless of statement order.
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_vld   <= w_vld_nxt;
    end
  end

  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;

endmodule

// File: doc/rr_grant_encoder.md
Name: rr_grant_encoder

Overview:
- Round-robin arbiter for 8 requesters.
- Produces a binary grant index plus a grant-valid strobe; these drive the 3-bit select and enable inputs of the downstream 3-to-8 one-hot decoder.
- Holds each grant until the owner signals completion or withdraws its request.
- Rotates priority so that no requester starves.

Parameters:
- IDX_W, 3, width of the grant index. NREQ must equal 2**IDX_W.
- NREQ, 8, number of requesters.
- MAX_HOLD, 16, maximum grant length in cycles. Used only when the optional feature is compiled in. Legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  request vector; bit i = requester i wants the resource.
- done  in  1  current owner finished; sampled only in GRANT.
- gnt_idx  out  IDX_W  index of the granted requester; feeds decoder select.
- gnt_vld  out  1  grant active; feeds decoder enable.
- timeout  out  1  one-cycle pulse on forced release (optional feature; otherwise tied 0).

Behaviour:
- Reset is asynchronous, active-high. While rst=1:
  - state=IDLE, ptr=0, gnt_idx=0, gnt_vld=0, timeout=0, hold counter=0.
  - Asserting rst mid-grant drops gnt_vld immediately, without waiting for a clock edge.
- All outputs are registered. There is no combinational path from any input to any output.
- ptr (IDX_W bits) holds the highest-priority index for the next arbitration.
- State IDLE:
  - If req==0: stay in IDLE; gnt_vld=0.
  - Else: winner = first set bit of req, scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - Next edge: gnt_idx<=winner, gnt_vld<=1, state<=GRANT.
  - Latency: 1 cycle from req sampled to gnt_vld high.
- State GRANT:
  - gnt_idx stays stable and gnt_vld stays 1.
  - Release condition: done=1 OR req[gnt_idx]=0.
  - On release, next edge: gnt_vld<=0, ptr<=gnt_idx+1 (7 wraps to 0), state<=IDLE.
  - done and a request drop in the same cycle count as a single release.
  - Requests from other bits during GRANT are ignored; they are arbitrated at the next IDLE.
- Mandatory bubble: at least one IDLE cycle with gnt_vld=0 between consecutive grants. The decoder output therefore goes all-zero between owners.
- gnt_idx holds its last value while gnt_vld=0. Consumers must qualify it with gnt_vld.
- done asserted in IDLE is ignored.
- Priority rotation:
  - A requester that held the grant gets lowest priority in the next arbitration.
  - A single persistent requester is re-granted after the bubble.
- Worst-case wait for any continuously asserted request: (NREQ-1) full grants plus bubbles.

Optional Feature:
- Macro: RR_GRANT_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - If the counter reaches MAX_HOLD-1 without a release condition, the next edge forces release: gnt_vld<=0, ptr<=gnt_idx+1, state<=IDLE, timeout<=1 for exactly one cycle.
  - A normal release in the same cycle takes precedence: timeout stays 0.
- Undefined:
  - No counter is instantiated and timeout is tied 0.
  - A grant is held indefinitely until done or the request drops.

Test Plan:
- Reset: assert rst mid-grant (gnt_idx=5, gnt_vld=1), no clock edge -> gnt_vld=0 immediately; after release, ptr=0 and the first arbitration with req=8'hFF grants idx 0.
- Rotation: hold req=8'hFF, pulse done each grant -> gnt_idx sequence 0,1,2,...,7,0, each grant separated by exactly one gnt_vld=0 cycle.
- Wrap and skip: with ptr=6, req=8'b0000_0101 -> grant idx 0; after done, grant idx 2; after done, grant idx 0.
- Request withdrawal: grant idx 3, then drop req[3] with done=0 -> gnt_vld=0 next edge, ptr=4; a pending req[1] is granted one cycle later.
- Simultaneous events: done=1 and req[gnt_idx]=0 in the same cycle -> single release, one bubble cycle, no double ptr advance. done pulsed in IDLE -> no effect.
- Timeout (RR_GRANT_TIMEOUT_EN, MAX_HOLD=16): req=8'h10 held, done never asserted -> gnt_vld high for exactly 16 cycles, timeout pulses once, then one bubble, then re-grant idx 4. Without the macro, gnt_vld stays high for 100+ cycles and timeout=0.
